// File: rtl/noise_env_len_if.sv
`default_nettype none
// ============================================================================
// Module      : noise_env_len_if
// Description : Register/tick/gate inputs and mixer outputs of the noise
//               envelope + length stage.
// Revision    : 1.0
// ============================================================================
interface noise_env_len_if;
    logic [7:0] r400c;
    logic [7:0] r400f;
    logic       r400f_wr;
    logic       chan_en;
    logic       qframe;
    logic       hframe;
    logic       noise_en;
    logic [3:0] sample;
    logic       active;

    modport master (
        output r400c, r400f, r400f_wr, chan_en, qframe, hframe, noise_en,
        input  sample, active
    );

    modport slave (
        input  r400c, r400f, r400f_wr, chan_en, qframe, hframe, noise_en,
        output sample, active
    );
endinterface
`default_nettype wire

// File: rtl/noise_env_len.sv
`default_nettype none
// ============================================================================
// Module      : noise_env_len
// Description : Noise channel envelope/constant-volume unit and length counter,
//               producing the 4-bit noise sample for the mixer.
// Revision    : 1.0
// ============================================================================
module noise_env_len #(
    parameter bit OUT_REG = 1'b1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    noise_env_len_if.slave     bus
);

    logic [7:0] r_len_cnt;
    logic [3:0] r_decay;
    logic [3:0] r_env_div;
    logic       r_start;

    logic       w_loop;
    logic       w_const;
    logic [3:0] w_period;
    logic [7:0] w_len_load;
    logic       w_len_nz;
    logic [3:0] w_volume;
    logic [3:0] w_sample;

    assign w_loop   = bus.r400c[5];
    assign w_const  = bus.r400c[4];
    assign w_period = bus.r400c[3:0];
    assign w_len_nz = (r_len_cnt != 8'h00);

    always_comb begin
        w_len_load = 8'h00;
        case ({bus.r400f[3], bus.r400f[7:4]})
            5'h00: w_len_load = 8'h0a;
            5'h01: w_len_load = 8'h14;
            5'h02: w_len_load = 8'h28;
            5'h03: w_len_load = 8'h50;
            5'h04: w_len_load = 8'ha0;
            5'h05: w_len_load = 8'h3c;
            5'h06: w_len_load = 8'h0e;
            5'h07: w_len_load = 8'h1a;
            5'h08: w_len_load = 8'h0c;
            5'h09: w_len_load = 8'h18;
            5'h0a: w_len_load = 8'h30;
            5'h0b: w_len_load = 8'h60;
            5'h0c: w_len_load = 8'hc0;
            5'h0d: w_len_load = 8'h48;
            5'h0e: w_len_load = 8'h10;
            5'h0f: w_len_load = 8'h20;
            5'h10: w_len_load = 8'hfe;
            // Upper half of the second table is simply 2*index.
            default: w_len_load = {3'b000, bus.r400f[7:4], 1'b0};
        endcase
    end

    // Channel disable dominates; a write reloads even on a half-frame tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len_cnt <= 8'h00;
        end else if (!bus.chan_en) begin
            r_len_cnt <= 8'h00;
        end else if (bus.r400f_wr) begin
            r_len_cnt <= w_len_load;
        end else if (bus.hframe && w_len_nz && !w_loop) begin
            r_len_cnt <= r_len_cnt - 8'h01;
        end
    end

    // The quarter-frame step uses the start flag as it was before this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start   <= 1'b0;
            r_decay   <= 4'h0;
            r_env_div <= 4'h0;
        end else begin
            if (bus.qframe) begin
                if (r_start) begin
                    r_decay   <= 4'hf;
                    r_env_div <= w_period;
                end else if (r_env_div == 4'h0) begin
                    r_env_div <= w_period;
                    if (r_decay != 4'h0) begin
                        r_decay <= r_decay - 4'h1;
                    end else if (w_loop) begin
                        r_decay <= 4'hf;
                    end
                end else begin
                    r_env_div <= r_env_div - 4'h1;
                end
            end
            if (bus.r400f_wr) begin
                r_start <= 1'b1;
            end else if (bus.qframe) begin
                r_start <= 1'b0;
            end
        end
    end

    assign w_volume = w_const ? w_period : r_decay;
    assign w_sample = (w_len_nz && bus.noise_en) ? w_volume : 4'h0;

    generate
        if (OUT_REG) begin : g_out_reg
            logic [3:0] r_sample;
            logic       r_active;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sample <= 4'h0;
                    r_active <= 1'b0;
                end else begin
                    r_sample <= w_sample;
                    r_active <= w_len_nz;
                end
            end

            assign bus.sample = r_sample;
            assign bus.active = r_active;
        end else begin : g_out_comb
            assign bus.sample = w_sample;
            assign bus.active = w_len_nz;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_noise_env_len.sv
`default_nettype none
// ============================================================================
// Module      : tb_noise_env_len
// Description : Directed scoreboard bench for noise_env_len (OUT_REG=1).
// Revision    : 1.0
// ============================================================================
module tb_noise_env_len;

    typedef struct {
        int         cyc;
        logic [3:0] smp;
        logic       act;
        string      name;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;
    exp_t exp_q[$];

    noise_env_len_if bus();

    noise_env_len #(.OUT_REG(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: outputs are checked mid-cycle, against entries due this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            total = total + 1;
            if (e.cyc < cyc) begin
                bad = bad + 1;
                $display("FAIL %s: check missed (due cyc %0d, now %0d)", e.name, e.cyc, cyc);
            end else if (bus.sample !== e.smp || bus.active !== e.act) begin
                bad = bad + 1;
                $display("FAIL %s: sample=%h active=%b, expected sample=%h active=%b",
                         e.name, bus.sample, bus.active, e.smp, e.act);
            end
        end
    end

    // Expected output after the next edge, given current state and inputs.
    task automatic chk(input string name, input logic [3:0] s, input logic a);
        exp_t e;
        e.cyc  = cyc + 1;
        e.smp  = s;
        e.act  = a;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc   = 0;
        total = 0;
        bad   = 0;
        rst          = 1'b1;
        bus.r400c    = 8'h00;
        bus.r400f    = 8'h00;
        bus.r400f_wr = 1'b0;
        bus.chan_en  = 1'b0;
        bus.qframe   = 1'b0;
        bus.hframe   = 1'b0;
        bus.noise_en = 1'b0;
        tick(2);
        chk("reset", 4'h0, 1'b0);
        tick();

        // 1: constant volume 15, gated by noise_en
        rst = 1'b0; bus.chan_en = 1'b1; bus.r400c = 8'h3f;
        bus.r400f = 8'h08; bus.r400f_wr = 1'b1; bus.noise_en = 1'b1;
        tick();
        bus.r400f_wr = 1'b0;
        chk("t1_on", 4'hf, 1'b1); tick();
        bus.noise_en = 1'b0;
        chk("t1_gate", 4'h0, 1'b1); tick();

        // 2: length 0x0a runs out after ten half-frames
        bus.r400c = 8'h00; bus.r400f = 8'h00; bus.r400f_wr = 1'b1;
        tick();
        bus.r400f_wr = 1'b0;
        bus.hframe = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t2_len_h%0d", i), 4'h0, 1'b1);
            tick();
        end
        bus.hframe = 1'b0;
        chk("t2_drop", 4'h0, 1'b0); tick();
        bus.hframe = 1'b1; tick(); bus.hframe = 1'b0;
        chk("t2_nowrap", 4'h0, 1'b0); tick();

        // 3: halt freezes the counter; disable clears it
        bus.r400c = 8'h3a; bus.r400f = 8'h00; bus.r400f_wr = 1'b1; bus.noise_en = 1'b1;
        tick();
        bus.r400f_wr = 1'b0;
        bus.hframe = 1'b1; tick(50); bus.hframe = 1'b0;
        chk("t3_halt", 4'ha, 1'b1); tick();
        bus.chan_en = 1'b0;
        chk("t3_dis_lat", 4'ha, 1'b1); tick();
        chk("t3_dis", 4'h0, 1'b0); tick();
        bus.chan_en = 1'b1;

        // 4: envelope period 2 steps decay every 3 quarter-frames
        bus.r400c = 8'h02; bus.r400f = 8'h08; bus.r400f_wr = 1'b1;
        tick();
        bus.r400f_wr = 1'b0;
        bus.qframe = 1'b1; tick(); bus.qframe = 1'b0;
        chk("t4_start", 4'hf, 1'b1); tick();
        for (int d = 14; d >= 0; d--) begin
            bus.qframe = 1'b1; tick(3); bus.qframe = 1'b0;
            if (d == 14 || d == 7 || d == 0) begin
                chk($sformatf("t4_decay%0d", d), 4'(d), 1'b1);
            end
            tick();
        end
        bus.qframe = 1'b1; tick(3); bus.qframe = 1'b0;
        chk("t4_hold0", 4'h0, 1'b1); tick();
        bus.r400c = 8'h22;
        bus.qframe = 1'b1; tick(3); bus.qframe = 1'b0;
        chk("t4_loop", 4'hf, 1'b1); tick();

        // 5: period 0, then write coincident with hframe and qframe
        bus.r400c = 8'h00;
        bus.qframe = 1'b1; tick(4); bus.qframe = 1'b0;
        chk("t5_per0", 4'hd, 1'b1); tick();
        bus.r400f = 8'h18; bus.r400f_wr = 1'b1; bus.hframe = 1'b1; bus.qframe = 1'b1;
        tick();
        bus.r400f_wr = 1'b0; bus.hframe = 1'b0; bus.qframe = 1'b0;
        chk("t5_coinc", 4'hc, 1'b1); tick();
        bus.qframe = 1'b1; tick(); bus.qframe = 1'b0;
        chk("t5_restart", 4'hf, 1'b1); tick();
        bus.hframe = 1'b1; tick(); bus.hframe = 1'b0;
        chk("t5_len1", 4'hf, 1'b1); tick();
        bus.hframe = 1'b1; tick(); bus.hframe = 1'b0;
        chk("t5_len0", 4'h0, 1'b0); tick();

        // 6: reset mid-note, then write while disabled
        bus.r400f = 8'ha0; bus.r400f_wr = 1'b1;
        tick();
        bus.r400f_wr = 1'b0;
        bus.qframe = 1'b1; tick(9); bus.qframe = 1'b0;
        chk("t6_pre", 4'h7, 1'b1); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_rst", 4'h0, 1'b0); tick();
        bus.chan_en = 1'b0; bus.r400f = 8'h08; bus.r400f_wr = 1'b1;
        tick();
        bus.r400f_wr = 1'b0;
        chk("t6_dis_wr", 4'h0, 1'b0); tick();
        bus.chan_en = 1'b1; bus.r400f_wr = 1'b1;
        tick();
        bus.r400f_wr = 1'b0;
        chk("t6_decay0", 4'h0, 1'b1); tick();

        tick(3);
        if (exp_q.size() != 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL drain: %0d checks left unconsumed, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
